output_port_bank: RTL

Parametrised memory-mapped output peripheral with multiple channels and per-channel PWM dimming. It sits on the core's output bus (output_address / output_in / output_size / output_write_enable / output_out) and drives NUM_CH channels of CH_WIDTH pins each. It supports byte, halfword and word writes, registered read-back, and a shared prescaled PWM timebase.

---
 rtl/output_port_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/output_port_bank.sv
// Memory-mapped multi-channel output bank: per-channel data and PWM duty registers,
// a shared prescaled PWM timebase, registered pins and registered read-back.
module output_port_bank #(
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 8,
  parameter int DUTY_BITS  = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  output_address,
  input  logic [31:0]                  output_in,
  input  logic [1:0]                   output_size,
  input  logic                         output_write_enable,
  output logic [31:0]                  output_out,
  output logic [NUM_CH*CH_WIDTH-1:0]   out_pins
);

  logic [CH_WIDTH-1:0]        r_data [NUM_CH];
  logic [DUTY_BITS-1:0]       r_duty [NUM_CH];
  logic [NUM_CH-1:0]          r_ctrl;
  logic [PRESCALE_W-1:0]      r_prescale;
  logic [PRESCALE_W-1:0]      r_pre_cnt;
  logic [DUTY_BITS-1:0]       r_pwm_cnt;
  logic [31:0]                r_out;
  logic [NUM_CH*CH_WIDTH-1:0] r_pins;

  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_mask;
  logic [31:0] w_wdat;
  logic [31:0] w_rdata;
  logic        w_wr;
  logic        w_sel_data;
  logic        w_sel_duty;
  logic        w_sel_ctrl;
  logic        w_sel_pre;
  logic        w_tick;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign w_off      = output_address[1:0];
  assign w_sel_data = (output_address[31:5] == 27'd0);
  assign w_sel_duty = (output_address[31:5] == 27'd1);
  assign w_sel_ctrl = (output_address[31:2] == 30'h10);
  assign w_sel_pre  = (output_address[31:2] == 30'h11);
  assign w_tick     = (r_pre_cnt >= r_prescale);

  // Misaligned halfword/word accesses produce an empty lane mask and are dropped.
  always_comb begin
    w_be = 4'b0000;
    case (output_size)
      2'd0:    w_be = 4'b0001 << w_off;
      2'd1:    if (!w_off[0]) w_be = 4'b0011 << w_off;
      default: if (w_off == 2'd0) w_be = 4'b1111;
    endcase
  end

  assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_wdat = output_in << {w_off, 3'b000};
  assign w_wr   = output_write_enable && (w_be != 4'b0000);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel_data && output_address[4:2] == 3'(i)) w_rdata = 32'(r_data[i]);
      if (w_sel_duty && output_address[4:2] == 3'(i)) w_rdata = 32'(r_duty[i]);
    end
    if (w_sel_ctrl) w_rdata = 32'(r_ctrl);
    if (w_sel_pre)  w_rdata = 32'(r_prescale);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '{default: '0};
      r_duty     <= '{default: '0};
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_out      <= '0;
      r_pins     <= '0;
    end else begin
      r_out <= w_rdata;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr && w_sel_data && output_address[4:2] == 3'(i))
          r_data[i] <= CH_WIDTH'(merge_lanes(32'(r_data[i]), w_wdat, w_mask));
        if (w_wr && w_sel_duty && output_address[4:2] == 3'(i))
          r_duty[i] <= DUTY_BITS'(merge_lanes(32'(r_duty[i]), w_wdat, w_mask));
        // Pins use the register and counter state left by the previous edge.
        r_pins[i*CH_WIDTH +: CH_WIDTH] <= (r_ctrl[i] && !(r_pwm_cnt < r_duty[i])) ?
                                          '0 : r_data[i];
      end
      if (w_wr && w_sel_ctrl)
        r_ctrl <= NUM_CH'(merge_lanes(32'(r_ctrl), w_wdat, w_mask));
      if (w_wr && w_sel_pre)
        r_prescale <= PRESCALE_W'(merge_lanes(32'(r_prescale), w_wdat, w_mask));

      // A PRESCALE write restarts the prescaler; the PWM counter keeps its phase.
      if (w_wr && w_sel_pre) r_pre_cnt <= '0;
      else if (w_tick)       r_pre_cnt <= '0;
      else                   r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + DUTY_BITS'(1);
    end
  end

  assign output_out = r_out;
  assign out_pins   = r_pins;

endmodule
